// File: rtl/tdest_tuser_pkg.sv
// ----------------------------------------------------------------------------
// Package: tdest_tuser_pkg
// Shared helpers and types for the tdest->tuser swap register slice.
//   - max/clog helpers used for port-width expressions
//   - id_w/dest_w/beat_w width functions (zero-width fields collapse to 1 bit)
//   - axis_beat_t: beat layout {data,id,dest,keep,last} at default widths
//   - slice_state_e: occupancy states of the 2-entry skid slice
// ----------------------------------------------------------------------------
package tdest_tuser_pkg;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to index 'v' entries (minimum 1).
  function automatic int clog_int(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return max_int(1, r);
  endfunction

  // A configured width of 0 still yields a 1-bit port, tied off internally.
  function automatic int id_w(input int id_width);
    return max_int(1, id_width);
  endfunction

  function automatic int dest_w(input int dest_width);
    return max_int(1, dest_width);
  endfunction

  function automatic int beat_w(input int bus_width, input int id_width,
                                input int dest_width);
    return bus_width + id_w(id_width) + dest_w(dest_width) + bus_width / 8 + 1;
  endfunction

  localparam int DEF_BUS_WIDTH  = 64;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DEST_WIDTH = 4;
  localparam int DEF_ID_W       = id_w(DEF_ID_WIDTH);
  localparam int DEF_DEST_W     = dest_w(DEF_DEST_WIDTH);

  typedef struct packed {
    logic [DEF_BUS_WIDTH-1:0]   data;
    logic [DEF_ID_W-1:0]        id;
    logic [DEF_DEST_W-1:0]      dest;
    logic [DEF_BUS_WIDTH/8-1:0] keep;
    logic                       last;
  } axis_beat_t;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_state_e;

endpackage

// File: rtl/axis_skid_slice.sv
// ----------------------------------------------------------------------------
// Module: axis_skid_slice
// Generic full-throughput 2-entry register slice on a packed beat vector.
// 'main' drives the output; 'skid' absorbs the one beat that arrives in the
// cycle downstream stalls, so in_ready can be a plain register.
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   in_data/valid/ready upstream side (in_ready registered)
//   out_data/valid/ready downstream side (out_data/out_valid registered)
// ----------------------------------------------------------------------------
module axis_skid_slice
  import tdest_tuser_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  slice_state_e state_q, state_n;
  logic [W-1:0] main_q, skid_q;
  logic         in_ready_q, in_ready_n;
  logic         accept, pop;
  logic         load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != SLICE_EMPTY);
  assign pop       = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_n        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      SLICE_EMPTY: begin
        if (accept) begin
          state_n      = SLICE_ONE;
          load_main_in = 1'b1;
        end
      end
      SLICE_ONE: begin
        if (accept && !pop) begin
          state_n   = SLICE_FULL;
          load_skid = 1'b1;
        end else if (pop && !accept) begin
          state_n = SLICE_EMPTY;
        end else if (accept && pop) begin
          load_main_in = 1'b1;
        end
      end
      SLICE_FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (pop) begin
          state_n        = SLICE_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_n = SLICE_EMPTY;
    endcase
    in_ready_n = (state_n != SLICE_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= SLICE_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
    end else begin
      state_q    <= state_n;
      in_ready_q <= in_ready_n;
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
    end
  end

  // NOTE: skid data carries no reset; it is never observed before being written
  // because the FULL state is required to read it.
  always_ff @(posedge aclk) begin
    if (load_skid) skid_q <= in_data;
  end

endmodule

// File: rtl/tdest_tuser_swap_reg.sv
// ----------------------------------------------------------------------------
// Module: tdest_tuser_swap_reg
// Registered AXI-Stream converter moving tdest onto tuser (egress inverse of
// the tuser->tdest swap). Built on a 2-entry skid slice: full throughput,
// registered tready and registered outputs, 1-cycle latency when empty.
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   axis_in_t{data,id,dest,keep,last,valid}, axis_in_tready   upstream
//   axis_out_t{data,id,user,keep,last,valid}, axis_out_tready downstream
// Configuration macro: TDEST_PKT_LATCH_EN
//   defined   : tdest sampled on the first beat of each packet; all beats of
//               that packet carry it on tuser.
//   undefined : tuser is the tdest of the same beat.
// ----------------------------------------------------------------------------
module tdest_tuser_swap_reg
  import tdest_tuser_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  localparam int ID_W   = id_w(AXIS_ID_WIDTH),
  localparam int DEST_W = dest_w(AXIS_DEST_WIDTH)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [ID_W-1:0]             axis_in_tid,
  input  logic [DEST_W-1:0]           axis_in_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [ID_W-1:0]             axis_out_tid,
  output logic [DEST_W-1:0]           axis_out_tuser,
  output logic [AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready
);

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0]   data;
    logic [ID_W-1:0]             id;
    logic [DEST_W-1:0]           dest;
    logic [AXIS_BUS_WIDTH/8-1:0] keep;
    logic                        last;
  } slice_beat_t;

  localparam int BEAT_W = $bits(slice_beat_t);

  slice_beat_t       in_beat, out_beat;
  logic [BEAT_W-1:0] out_vec;
  logic [DEST_W-1:0] dest_mapped;

`ifdef TDEST_PKT_LATCH_EN
  logic              sop;
  logic [DEST_W-1:0] dest_hold;
  logic              accept;

  assign accept = axis_in_tvalid && axis_in_tready;

  // sop marks that the next accepted beat opens a packet; reset discards any
  // partial packet so the first beat afterwards is always treated as sop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sop       <= 1'b1;
      dest_hold <= '0;
    end else if (accept) begin
      if (sop) dest_hold <= axis_in_tdest;
      sop <= axis_in_tlast;
    end
  end

  // The first beat uses its own tdest directly; dest_hold only catches up on
  // the same edge, so the remaining beats read the held copy.
  assign dest_mapped = sop ? axis_in_tdest : dest_hold;
`else
  assign dest_mapped = axis_in_tdest;
`endif

  always_comb begin
    in_beat.data = axis_in_tdata;
    in_beat.id   = (AXIS_ID_WIDTH == 0) ? '0 : axis_in_tid;
    in_beat.dest = (AXIS_DEST_WIDTH == 0) ? '0 : dest_mapped;
    in_beat.keep = axis_in_tkeep;
    in_beat.last = axis_in_tlast;
  end

  axis_skid_slice #(
    .W (BEAT_W)
  ) u_slice (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   (in_beat),
    .in_valid  (axis_in_tvalid),
    .in_ready  (axis_in_tready),
    .out_data  (out_vec),
    .out_valid (axis_out_tvalid),
    .out_ready (axis_out_tready)
  );

  assign out_beat       = slice_beat_t'(out_vec);
  assign axis_out_tdata = out_beat.data;
  assign axis_out_tid   = out_beat.id;
  assign axis_out_tuser = out_beat.dest;
  assign axis_out_tkeep = out_beat.keep;
  assign axis_out_tlast = out_beat.last;

endmodule

// File: tb/tb_tdest_tuser_swap_reg.sv
// ----------------------------------------------------------------------------
// Testbench for tdest_tuser_swap_reg (default widths 64/4/4). Compile with the
// same TDEST_PKT_LATCH_EN setting as the RTL.
// ----------------------------------------------------------------------------
module tb_tdest_tuser_swap_reg;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] axis_in_tdata;
  logic [3:0]  axis_in_tid;
  logic [3:0]  axis_in_tdest;
  logic [7:0]  axis_in_tkeep;
  logic        axis_in_tlast;
  logic        axis_in_tvalid;
  logic        axis_in_tready;
  logic [63:0] axis_out_tdata;
  logic [3:0]  axis_out_tid;
  logic [3:0]  axis_out_tuser;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast;
  logic        axis_out_tvalid;
  logic        axis_out_tready;

  always #5 aclk = ~aclk;

  tdest_tuser_swap_reg dut (
    .aclk            (aclk),
    .areset          (areset),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tid     (axis_in_tid),
    .axis_in_tdest   (axis_in_tdest),
    .axis_in_tkeep   (axis_in_tkeep),
    .axis_in_tlast   (axis_in_tlast),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tid    (axis_out_tid),
    .axis_out_tuser  (axis_out_tuser),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready)
  );

  // 'user' holds tdest on the input side and the expected tuser on the output.
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic [3:0]  user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t exp_q[$];

`ifdef TDEST_PKT_LATCH_EN
  bit         m_sop  = 1'b1;
  logic [3:0] m_dest = 4'h0;
`endif

  // Reference: packet-level rule for the destination carried on tuser.
  function automatic beat_t model_accept(input beat_t b);
    beat_t e;
    e = b;
`ifdef TDEST_PKT_LATCH_EN
    if (m_sop) m_dest = b.user;
    m_sop  = b.last;
    e.user = m_dest;
`endif
    return e;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
`ifdef TDEST_PKT_LATCH_EN
    m_sop = 1'b1;
`endif
  endfunction

  function automatic beat_t observed();
    beat_t o;
    o.data = axis_out_tdata;
    o.id   = axis_out_tid;
    o.user = axis_out_tuser;
    o.keep = axis_out_tkeep;
    o.last = axis_out_tlast;
    return o;
  endfunction

  function automatic beat_t rand_beat(input logic [3:0] dest, input logic last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.id   = 4'($urandom_range(15));
    b.user = dest;
    b.keep = 8'($urandom_range(255));
    b.last = last;
    return b;
  endfunction

  task automatic drive(input beat_t b, input logic valid);
    axis_in_tdata  = b.data;
    axis_in_tid    = b.id;
    axis_in_tdest  = b.user;
    axis_in_tkeep  = b.keep;
    axis_in_tlast  = b.last;
    axis_in_tvalid = valid;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    axis_out_tready = 1'b1;
    drive(rand_beat(4'h3, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      n_checks++;
      if (axis_out_tvalid !== 1'b0 || axis_in_tready !== 1'b0 ||
          axis_out_tdata !== 64'h0 || axis_out_tuser !== 4'h0) begin
        $display("FAIL reset_hold[%0d]: out_tvalid=%b in_tready=%b tdata=%h tuser=%h, required 0/0/0/0",
                 i, axis_out_tvalid, axis_in_tready, axis_out_tdata, axis_out_tuser);
      end else n_pass++;
    end
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (axis_in_tready !== 1'b1 || axis_out_tvalid !== 1'b0) begin
      $display("FAIL reset_release: in_tready=%b out_tvalid=%b, required 1/0",
               axis_in_tready, axis_out_tvalid);
    end else n_pass++;
    axis_in_tvalid = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    beat_t b, e;
    b = rand_beat(4'h5, 1'b0);
    axis_out_tready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge aclk); #1;
      if (c < 16) begin
        b = rand_beat(4'h5, c == 15);
        drive(b, 1'b1);
      end else axis_in_tvalid = 1'b0;
      @(negedge aclk);
      n_checks++;
      if (c >= 1 && c <= 16) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (axis_out_tvalid !== 1'b1 || observed() !== e || axis_out_tuser !== 4'h5 ||
            (c < 16 && axis_in_tready !== 1'b1)) begin
          $display("FAIL stream_beat[%0d]: valid=%b ready=%b got %h required %h",
                   c - 1, axis_out_tvalid, axis_in_tready, observed(), e);
        end else n_pass++;
      end else begin
        if (axis_out_tvalid !== 1'b0) begin
          $display("FAIL stream_idle[%0d]: out_tvalid=%b required 0", c, axis_out_tvalid);
        end else n_pass++;
      end
      if (axis_in_tvalid && axis_in_tready) exp_q.push_back(model_accept(b));
    end
  endtask

  task automatic test_backpressure();
    beat_t a, b, ea, eb;
    a = rand_beat(4'($urandom_range(15)), 1'b1);
    b = rand_beat(4'($urandom_range(15)), 1'b1);
    ea = model_accept(a);
    eb = model_accept(b);
    @(posedge aclk); #1;
    axis_out_tready = 1'b0;
    drive(a, 1'b1);
    @(negedge aclk);
    n_checks++;
    if (axis_in_tready !== 1'b1) $display("FAIL bp_accept0: in_tready=%b required 1", axis_in_tready);
    else n_pass++;
    @(posedge aclk); #1;
    drive(b, 1'b1);
    @(negedge aclk);
    n_checks++;
    if (axis_in_tready !== 1'b1 || axis_out_tvalid !== 1'b1 || observed() !== ea)
      $display("FAIL bp_accept1: ready=%b valid=%b got %h required %h",
               axis_in_tready, axis_out_tvalid, observed(), ea);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      axis_in_tvalid = 1'b0;
      @(negedge aclk);
      n_checks++;
      if (axis_in_tready !== 1'b0 || axis_out_tvalid !== 1'b1 || observed() !== ea)
        $display("FAIL bp_held[%0d]: ready=%b valid=%b got %h required %h",
                 i, axis_in_tready, axis_out_tvalid, observed(), ea);
      else n_pass++;
    end
    @(posedge aclk); #1;
    axis_out_tready = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (axis_out_tvalid !== 1'b1 || observed() !== ea)
      $display("FAIL bp_release0: valid=%b got %h required %h", axis_out_tvalid, observed(), ea);
    else n_pass++;
    @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (axis_in_tready !== 1'b1 || axis_out_tvalid !== 1'b1 || observed() !== eb)
      $display("FAIL bp_release1: ready=%b valid=%b got %h required %h",
               axis_in_tready, axis_out_tvalid, observed(), eb);
    else n_pass++;
    @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (axis_out_tvalid !== 1'b0) $display("FAIL bp_drained: out_tvalid=%b required 0", axis_out_tvalid);
    else n_pass++;
  endtask

  task automatic test_random();
    beat_t cur, e;
    int    sent = 0;
    int    cyc  = 0;
    bit    pending = 1'b0;
    cur = rand_beat(4'h0, 1'b1);
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      @(posedge aclk); #1;
      if (!pending) begin
        if (sent < 1000 && $urandom_range(1) == 1) begin
          cur = rand_beat(4'($urandom_range(15)),
                          (sent == 999) ? 1'b1 : ($urandom_range(3) == 0));
          drive(cur, 1'b1);
          pending = 1'b1;
        end else axis_in_tvalid = 1'b0;
      end
      axis_out_tready = (sent >= 1000) ? 1'b1 : 1'($urandom_range(1));
      @(negedge aclk);
      if (axis_out_tvalid && axis_out_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra: unexpected beat %h", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) $display("FAIL rand_beat: got %h required %h", observed(), e);
          else n_pass++;
        end
      end
      if (axis_in_tvalid && axis_in_tready) begin
        exp_q.push_back(model_accept(cur));
        sent++;
        pending = 1'b0;
      end
      cyc++;
    end
    axis_in_tvalid = 1'b0;
    n_checks++;
    if (sent != 1000 || exp_q.size() != 0)
      $display("FAIL rand_complete: sent=%0d outstanding=%0d cycles=%0d, required 1000/0",
               sent, exp_q.size(), cyc);
    else n_pass++;
  endtask

  task automatic test_latch();
    logic [3:0]  dests [4] = '{4'h2, 4'h7, 4'h9, 4'h6};
    logic        lasts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef TDEST_PKT_LATCH_EN
    logic [3:0]  users [4] = '{4'h2, 4'h2, 4'h2, 4'h6};
`else
    logic [3:0]  users [4] = '{4'h2, 4'h7, 4'h9, 4'h6};
`endif
    logic [63:0] datas [4];
    beat_t b;
    axis_out_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge aclk); #1;
      if (c < 4) begin
        b = rand_beat(dests[c], lasts[c]);
        datas[c] = b.data;
        drive(b, 1'b1);
      end else axis_in_tvalid = 1'b0;
      @(negedge aclk);
      if (c < 4 && axis_in_tvalid && axis_in_tready) b = model_accept(b);
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (axis_out_tvalid !== 1'b1 || axis_out_tuser !== users[c-1] ||
            axis_out_tdata !== datas[c-1])
          $display("FAIL latch_tuser[%0d]: valid=%b tuser=%h tdata=%h required tuser=%h tdata=%h",
                   c - 1, axis_out_tvalid, axis_out_tuser, axis_out_tdata, users[c-1], datas[c-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    beat_t b;
    axis_out_tready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge aclk); #1;
      drive(rand_beat(4'(3 + c), 1'b0), 1'b1);
      @(negedge aclk);
      n_checks++;
      if (axis_in_tready !== 1'b1) $display("FAIL midrst_accept[%0d]: in_tready=%b required 1", c, axis_in_tready);
      else n_pass++;
    end
    @(posedge aclk); #1;
    axis_in_tvalid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    @(negedge aclk);
    n_checks++;
    if (axis_out_tvalid !== 1'b0 || axis_in_tready !== 1'b0 || axis_out_tdata !== 64'h0)
      $display("FAIL midrst_flush: valid=%b ready=%b tdata=%h required 0/0/0",
               axis_out_tvalid, axis_in_tready, axis_out_tdata);
    else n_pass++;
    @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (axis_in_tready !== 1'b1 || axis_out_tvalid !== 1'b0)
      $display("FAIL midrst_release: ready=%b valid=%b required 1/0", axis_in_tready, axis_out_tvalid);
    else n_pass++;
    @(posedge aclk); #1;
    b = rand_beat(4'hA, 1'b1);
    drive(b, 1'b1);
    axis_out_tready = 1'b1;
    @(posedge aclk); #1;
    axis_in_tvalid = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (axis_out_tvalid !== 1'b1 || axis_out_tuser !== 4'hA || axis_out_tdata !== b.data)
      $display("FAIL midrst_sop: valid=%b tuser=%h tdata=%h required 1/a/%h",
               axis_out_tvalid, axis_out_tuser, axis_out_tdata, b.data);
    else n_pass++;
    @(posedge aclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset          = 1'b1;
    axis_in_tvalid  = 1'b0;
    axis_out_tready = 1'b0;
    axis_in_tdata   = '0;
    axis_in_tid     = '0;
    axis_in_tdest   = '0;
    axis_in_tkeep   = '0;
    axis_in_tlast   = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_latch();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
